// File: rtl/spi_slave_if.sv
// Byte-oriented SPI slave, mode 0, MSB first.
// The SPI pins are oversampled on clk. Received bytes go to the command controller
// with a packet-start flag. The controller's pending TX byte is shifted out on MISO.
// Ports:
//   clk, reset            system clock; synchronous active-low reset
//   spi_sck/cs_n/mosi     asynchronous SPI master inputs
//   spi_miso, spi_miso_oe serial output and its enable
//   rxData, rxPacketStart last received byte and its first-in-packet flag
//   rxDataRdySet          one-cycle pulse when rxData/rxPacketStart update
//   txData, txDataFull    next TX byte and its pending flag
//   txDataFullClr         one-cycle pulse when txData is loaded into the shifter
//   txDataEmpty           the byte now being shifted is IDLE_BYTE
module spi_slave_if #(
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [7:0] rxData,
    output logic       rxPacketStart,
    output logic       rxDataRdySet,
    input  logic [7:0] txData,
    input  logic       txDataFull,
    output logic       txDataFullClr,
    output logic       txDataEmpty
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sck_prev_q, cs_prev_q;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                first_byte_q, first_byte_d;
    logic [BYTE_W-1:0]   rx_shift_q, rx_shift_d;
    logic [BYTE_W-1:0]   tx_shift_q, tx_shift_d;
    logic                miso_q, miso_d;
    logic                miso_oe_q, miso_oe_d;
    logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_start_q, rx_start_d;
    logic                rx_rdy_q, rx_rdy_d;
    logic                tx_clr_q, tx_clr_d;
    logic                tx_empty_q, tx_empty_d;

    logic sck_s, cs_s, mosi_s;
    logic sck_rise_c, sck_fall_c, cs_fall_c, cs_rise_c;

    assign sck_s      = sck_sync_q[SYNC_STAGES-1];
    assign cs_s       = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise_c = sck_s & ~sck_prev_q;
    assign sck_fall_c = ~sck_s & sck_prev_q;
    assign cs_fall_c  = ~cs_s & cs_prev_q;
    assign cs_rise_c  = cs_s & ~cs_prev_q;

    // State and output registers. The CS chain resets low, so a CS that is already
    // low at reset release does not produce a falling edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sck_sync_q   <= '0;
            cs_sync_q    <= '0;
            mosi_sync_q  <= '0;
            sck_prev_q   <= 1'b0;
            cs_prev_q    <= 1'b0;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            first_byte_q <= 1'b1;
            rx_shift_q   <= '0;
            tx_shift_q   <= IDLE_BYTE;
            miso_q       <= 1'b1;
            miso_oe_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_start_q   <= 1'b0;
            rx_rdy_q     <= 1'b0;
            tx_clr_q     <= 1'b0;
            tx_empty_q   <= 1'b1;
        end else begin
            sck_sync_q   <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sck_prev_q   <= sck_s;
            cs_prev_q    <= cs_s;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            first_byte_q <= first_byte_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            miso_q       <= miso_d;
            miso_oe_q    <= miso_oe_d;
            rx_data_q    <= rx_data_d;
            rx_start_q   <= rx_start_d;
            rx_rdy_q     <= rx_rdy_d;
            tx_clr_q     <= tx_clr_d;
            tx_empty_q   <= tx_empty_d;
        end
    end

    // Next-state logic: CS framing, RX shift/deliver, TX shift/load.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        first_byte_d = first_byte_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        miso_d       = miso_q;
        rx_data_d    = rx_data_q;
        rx_start_d   = rx_start_q;
        rx_rdy_d     = 1'b0;
        tx_clr_d     = 1'b0;
        tx_empty_d   = tx_empty_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall_c) begin
                    state_d      = ST_ACTIVE;
                    bit_cnt_d    = '0;
                    first_byte_d = 1'b1;
                    if (txDataFull) begin
                        tx_shift_d = txData;
                        miso_d     = txData[BYTE_W-1];
                        tx_clr_d   = 1'b1;
                        tx_empty_d = 1'b0;
                    end else begin
                        tx_shift_d = IDLE_BYTE;
                        miso_d     = IDLE_BYTE[BYTE_W-1];
                        tx_empty_d = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                // CS release wins over any coincident SCK edge; partial bytes are dropped.
                if (cs_rise_c) begin
                    state_d = ST_IDLE;
                end else begin
                    if (sck_rise_c) begin
                        rx_shift_d = {rx_shift_q[BYTE_W-2:0], mosi_s};
                        bit_cnt_d  = CNT_W'(bit_cnt_q + CNT_W'(1));
                        if (bit_cnt_q == CNT_W'(7)) begin
                            rx_data_d    = {rx_shift_q[BYTE_W-2:0], mosi_s};
                            rx_start_d   = first_byte_q;
                            rx_rdy_d     = 1'b1;
                            first_byte_d = 1'b0;
                        end
                    end
                    if (sck_fall_c) begin
                        if (bit_cnt_q != '0) begin
                            tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
                            miso_d     = tx_shift_q[BYTE_W-2];
                        end else if (txDataFull) begin
                            tx_shift_d = txData;
                            miso_d     = txData[BYTE_W-1];
                            tx_clr_d   = 1'b1;
                            tx_empty_d = 1'b0;
                        end else begin
                            tx_shift_d = IDLE_BYTE;
                            miso_d     = IDLE_BYTE[BYTE_W-1];
                            tx_empty_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        miso_oe_d = (state_d == ST_ACTIVE);
    end

    assign spi_miso      = miso_q;
    assign spi_miso_oe   = miso_oe_q;
    assign rxData        = rx_data_q;
    assign rxPacketStart = rx_start_q;
    assign rxDataRdySet  = rx_rdy_q;
    assign txDataFullClr = tx_clr_q;
    assign txDataEmpty   = tx_empty_q;

endmodule
